snake_target_gen: RTL and testbench

//  Generates the food target for the snake game and feeds target_x/target_y to the snake steering FSM.
//  On each snake step it checks whether the head has reached the target.
//  On a hit it pulses eaten, bumps the score and draws a new grid-aligned target from an LFSR.

---
 rtl/snake_target_if.sv | 22 ++
 rtl/snake_target_gen.sv | 140 ++++++++++++++
 tb/tb_snake_target_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_target_if.sv
// Handshake bundle between the snake steering logic and the food target generator.
// The master drives the head position and step strobe; the slave returns the target.
interface snake_target_if;
  logic       tick;
  logic [9:0] head_x;
  logic [9:0] head_y;
  logic [9:0] target_x;
  logic [9:0] target_y;
  logic       target_valid;
  logic       eaten;
  logic [7:0] score;

  modport master (
    output tick, head_x, head_y,
    input  target_x, target_y, target_valid, eaten, score
  );

  modport slave (
    input  tick, head_x, head_y,
    output target_x, target_y, target_valid, eaten, score
  );
endinterface

// File: rtl/snake_target_gen.sv
// Food target generator: detects head-on-target hits, keeps score and
// draws new grid-aligned targets in the playfield quadrants from an LFSR.
module snake_target_gen #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          HIT_TOL   = 20,
  parameter int          MAX_TRIES = 64,
  parameter int          INIT_X    = 800,
  parameter int          INIT_Y    = 200
) (
  input  logic          clock_i,
  input  logic          reset_i,
  snake_target_if.slave bus
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic {HOLD, DRAW} state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [9:0]      tx_q, tx_d;
  logic [9:0]      ty_q, ty_d;
  logic            valid_q, valid_d;
  logic            eaten_q, eaten_d;
  logic [7:0]      score_q, score_d;
  logic [TW-1:0]   tries_q, tries_d;

  logic [1:0]      q;
  logic [5:0]      xi;
  logic [4:0]      yi;
  logic [9:0]      base_x, base_y;
  logic [9:0]      cand_x, cand_y;
  logic            accept;
  logic            hit;
  logic            init_near;

  // Signed 11-bit difference so that small heads never wrap into a hit.
  function automatic logic near(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    logic [10:0] m;
    d = {1'b0, a} - {1'b0, b};
    m = d[10] ? (~d + 11'd1) : d;
    return m < 11'(HIT_TOL);
  endfunction

  function automatic logic [9:0] mul10(input logic [5:0] v);
    return 10'({v, 3'b000}) + 10'({v, 1'b0});
  endfunction

  always_comb begin
    q      = lfsr_q[1:0];
    xi     = lfsr_q[7:2];
    yi     = lfsr_q[12:8];
    base_x = (q == 2'b01 || q == 2'b10) ? 10'd650 : 10'd300;
    base_y = q[1] ? 10'd330 : 10'd50;
    cand_x = base_x + mul10(xi);
    cand_y = base_y + mul10({1'b0, yi});
    accept = (xi <= 6'd32) && (yi <= 5'd26) &&
             !(cand_x == bus.head_x && cand_y == bus.head_y);
    hit       = near(bus.head_x, tx_q) && near(bus.head_y, ty_q);
    init_near = near(bus.head_x, 10'(INIT_X)) &&
                near(bus.head_y, 10'(INIT_Y));
  end

  always_comb begin
    if (lfsr_q == 16'd0)
      lfsr_d = SEED;
    else if (lfsr_q[0])
      lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
    else
      lfsr_d = lfsr_q >> 1;
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    valid_d = valid_q;
    eaten_d = 1'b0;
    score_d = score_q;
    tries_d = tries_q;
    unique case (state_q)
      HOLD: begin
        if (bus.tick && hit) begin
          eaten_d = 1'b1;
          if (score_q != 8'hFF)
            score_d = score_q + 8'd1;
          valid_d = 1'b0;
          tries_d = '0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (accept) begin
          tx_d    = cand_x;
          ty_d    = cand_y;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (tries_q == TW'(MAX_TRIES - 1)) begin
          tx_d    = init_near ? 10'd450 : 10'(INIT_X);
          ty_d    = init_near ? 10'd450 : 10'(INIT_Y);
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          tries_d = tries_q + TW'(1);
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= HOLD;
      lfsr_q  <= SEED;
      tx_q    <= 10'(INIT_X);
      ty_q    <= 10'(INIT_Y);
      valid_q <= 1'b1;
      eaten_q <= 1'b0;
      score_q <= 8'd0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      valid_q <= valid_d;
      eaten_q <= eaten_d;
      score_q <= score_d;
      tries_q <= tries_d;
    end
  end

  assign bus.target_x     = tx_q;
  assign bus.target_y     = ty_q;
  assign bus.target_valid = valid_q;
  assign bus.eaten        = eaten_q;
  assign bus.score        = score_q;

endmodule

// File: tb/tb_snake_target_gen.sv
// Bench for snake_target_gen: boundary vector table, corner sequences and
// random draws checked against an arithmetic reference model.
module tb_snake_target_gen;

  localparam int SEED = 'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snake_target_if bus();

  snake_target_gen dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  int m_tx, m_ty, m_score, m_tries, m_lfsr;
  bit m_valid, m_eaten, m_draw;
  int BX[4] = '{300, 650, 650, 300};
  int BY[4] = '{50, 50, 330, 330};

  typedef struct {
    int hx;
    int hy;
    bit tk;
    bit hit;
  } vec_t;
  vec_t vt[11];

  function automatic bit near(int ax, int ay, int bx, int by);
    int dx = ax - bx;
    int dy = ay - by;
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx < 20) && (dy < 20);
  endfunction

  function automatic bit in_quad(int x, int y);
    bit okx = (x >= 300 && x <= 620 && (x - 300) % 10 == 0) ||
              (x >= 650 && x <= 970 && (x - 650) % 10 == 0);
    bit oky = (y >= 50 && y <= 310 && (y - 50) % 10 == 0) ||
              (y >= 330 && y <= 590 && (y - 330) % 10 == 0);
    return okx && oky;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_cand(output int cx, output int cy, output bit ok);
    int q  = m_lfsr % 4;
    int xi = (m_lfsr / 4) % 64;
    int yi = (m_lfsr / 256) % 32;
    cx = BX[q] + 10 * xi;
    cy = BY[q] + 10 * yi;
    ok = (xi <= 32) && (yi <= 26);
  endtask

  task automatic m_step(bit r, bit tk, int hx, int hy);
    int nl, cx, cy;
    bit ok;
    if (r) begin
      m_tx = 800; m_ty = 200; m_valid = 1; m_eaten = 0;
      m_score = 0; m_lfsr = SEED; m_draw = 0; m_tries = 0;
      return;
    end
    if (m_lfsr == 0) nl = SEED;
    else if (m_lfsr % 2 == 1) nl = (m_lfsr / 2) ^ 'hB400;
    else nl = m_lfsr / 2;
    m_eaten = 0;
    if (!m_draw) begin
      if (tk && near(hx, hy, m_tx, m_ty)) begin
        m_eaten = 1;
        if (m_score < 255) m_score++;
        m_valid = 0;
        m_tries = 0;
        m_draw  = 1;
      end
    end else begin
      m_cand(cx, cy, ok);
      if (ok && !(cx == hx && cy == hy)) begin
        m_tx = cx; m_ty = cy; m_valid = 1; m_draw = 0;
      end else if (m_tries == 63) begin
        if (near(hx, hy, 800, 200)) begin
          m_tx = 450; m_ty = 450;
        end else begin
          m_tx = 800; m_ty = 200;
        end
        m_valid = 1; m_draw = 0;
      end else begin
        m_tries++;
      end
    end
    m_lfsr = nl;
  endtask

  task automatic compare_model();
    logic [29:0] act, exp;
    act = {bus.target_x, bus.target_y, bus.target_valid, bus.eaten, bus.score};
    exp = {10'(m_tx), 10'(m_ty), m_valid, m_eaten, 8'(m_score)};
    chk("model", int'(act), int'(exp));
  endtask

  task automatic cyc(bit r, bit tk, int hx, int hy);
    @(negedge clk);
    rst = r;
    bus.tick = tk;
    bus.head_x = 10'(hx);
    bus.head_y = 10'(hy);
    @(posedge clk);
    m_step(r, tk, hx, hy);
    #1;
    compare_model();
  endtask

  initial begin
    int n, pulses, draws, cycles, hx, hy, cx, cy;
    bit tk, pv, ok;

    vt[0]  = '{790, 210, 1, 1};
    vt[1]  = '{780, 200, 1, 0};
    vt[2]  = '{781, 200, 1, 1};
    vt[3]  = '{819, 219, 1, 1};
    vt[4]  = '{820, 200, 1, 0};
    vt[5]  = '{800, 181, 1, 1};
    vt[6]  = '{800, 180, 1, 0};
    vt[7]  = '{800, 220, 1, 0};
    vt[8]  = '{800, 200, 0, 0};
    vt[9]  = '{0, 0, 1, 0};
    vt[10] = '{1023, 1023, 1, 0};

    bus.tick = 1'b0;
    bus.head_x = '0;
    bus.head_y = '0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_tx", int'(bus.target_x), 800);
    chk("rst_ty", int'(bus.target_y), 200);
    chk("rst_valid", int'(bus.target_valid), 1);
    chk("rst_eaten", int'(bus.eaten), 0);
    chk("rst_score", int'(bus.score), 0);
    chk("rst_lfsr", int'(dut.lfsr_q), SEED);

    for (int i = 0; i < 11; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, vt[i].tk, vt[i].hx, vt[i].hy);
      chk($sformatf("vec%0d_eaten", i), int'(bus.eaten), int'(vt[i].hit));
      chk($sformatf("vec%0d_valid", i), int'(bus.target_valid), int'(!vt[i].hit));
      chk($sformatf("vec%0d_tx", i), int'(bus.target_x), 800);
      chk($sformatf("vec%0d_score", i), int'(bus.score), int'(vt[i].hit));
      cyc(0, 0, vt[i].hx, vt[i].hy);
      chk($sformatf("vec%0d_pulse", i), int'(bus.eaten), 0);
    end

    cyc(1, 0, 0, 0);
    cyc(0, 1, 790, 210);
    chk("hit_eaten", int'(bus.eaten), 1);
    chk("hit_score", int'(bus.score), 1);
    chk("hit_valid", int'(bus.target_valid), 0);
    n = 0;
    while (!bus.target_valid && n < 65) begin
      cyc(0, 0, 790, 210);
      n++;
    end
    chk("redraw_done", int'(bus.target_valid), 1);
    chk("redraw_quad", int'(in_quad(bus.target_x, bus.target_y)), 1);

    cyc(1, 0, 0, 0);
    cyc(0, 1, 800, 200);
    pulses = int'(bus.eaten);
    n = 0;
    while (!bus.target_valid && n < 70) begin
      cyc(0, 1, 800, 200);
      pulses += int'(bus.eaten);
      n++;
    end
    chk("draw_tick_pulses", pulses, 1);
    chk("draw_tick_score", int'(bus.score), 1);

    cyc(1, 0, 0, 0);
    for (int k = 0; k < 256; k++) begin
      n = 0;
      while (!bus.target_valid && n < 70) begin
        cyc(0, 0, 0, 0);
        n++;
      end
      cyc(0, 1, m_tx, m_ty);
    end
    chk("sat_score", int'(bus.score), 255);
    n = 0;
    while (!bus.target_valid && n < 70) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("sat_regen", int'(bus.target_valid), 1);

    cyc(1, 0, 0, 0);
    cyc(0, 1, 800, 200);
    chk("mid_in_draw", int'(bus.target_valid), 0);
    cyc(1, 0, 0, 0);
    chk("mid_tx", int'(bus.target_x), 800);
    chk("mid_ty", int'(bus.target_y), 200);
    chk("mid_valid", int'(bus.target_valid), 1);
    chk("mid_score", int'(bus.score), 0);
    chk("mid_lfsr", int'(dut.lfsr_q), SEED);

    draws = 0;
    cycles = 0;
    while (draws < 1000 && cycles < 40000) begin
      if (m_valid) begin
        if ($urandom_range(0, 9) < 6) begin
          hx = m_tx + int'($urandom_range(0, 50)) - 25;
          hy = m_ty + int'($urandom_range(0, 50)) - 25;
          tk = ($urandom_range(0, 3) != 0);
        end else begin
          hx = int'($urandom_range(0, 1023));
          hy = int'($urandom_range(0, 1023));
          tk = $urandom_range(0, 1) == 1;
        end
      end else begin
        m_cand(cx, cy, ok);
        if ($urandom_range(0, 9) < 3) begin
          hx = cx;
          hy = cy;
        end else begin
          hx = int'($urandom_range(0, 1023));
          hy = int'($urandom_range(0, 1023));
        end
        tk = $urandom_range(0, 1) == 1;
      end
      if (hx < 0) hx = 0;
      if (hy < 0) hy = 0;
      if (hx > 1023) hx = 1023;
      if (hy > 1023) hy = 1023;
      pv = m_valid;
      cyc(0, tk, hx, hy);
      cycles++;
      if (!pv && m_valid) begin
        draws++;
        chk("rnd_quad", int'(in_quad(bus.target_x, bus.target_y)), 1);
        chk("rnd_not_head",
            int'(int'(bus.target_x) != hx || int'(bus.target_y) != hy), 1);
      end
    end
    chk("rnd_draws", draws, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
